cnn_wr_packer: RTL and testbench
================================

Name: cnn_wr_packer

Overview:
- Downstream stage of the CNN datapath.
- Consumes the stream of signed dot-product/accumulator results produced by the CNN unit.
- Per result: optional ReLU, arithmetic right-shift requantisation, signed 8-bit saturation.
- Packs the resulting bytes into MEM_DATA_BUS-wide lines and writes them to memory over the write-client handshake (req/gnt), starting at the software-supplied return address.

Parameters:
- ADDR_WIDTH, 19, memory byte-address width.
- MEM_DATA_BUS, 128, memory data bus width in bits; BYTES_PER_LINE = MEM_DATA_BUS/8 = 16.
- RES_WIDTH, 32, width of incoming signed result.
- LOG2_BYTES, $clog2(MEM_DATA_BUS/8), width base for byte counters.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw_start  input  1  single-cycle start pulse; sampled only in IDLE.
- sw_addr_z  input  ADDR_WIDTH  first write byte address.
- sw_shift  input  5  right-shift amount (0..31).
- sw_relu_en  input  1  1 = clamp negatives to 0 before shifting.
- res_valid  input  1  result valid.
- res_data  input  RES_WIDTH  signed result.
- res_last  input  1  marks final result of the job.
- res_ready  output  1  packer accepts a result this cycle.
- mem_req  output  1  write request.
- mem_start_addr  output  ADDR_WIDTH  write byte address.
- mem_size_bytes  output  LOG2_BYTES+1  number of valid bytes in mem_data (1..16).
- mem_data  output  MEM_DATA_BUS  packed line; byte k is bits [8k+7:8k].
- last  output  1  this write is the final one of the job.
- mem_gnt  input  1  memory grant for current request.
- busy  output  1  job in progress.
- done  output  1  one-cycle pulse at job completion.

Behaviour:
- Clock/reset: one clock clk. Reset is asynchronous, active-high: rst.
- Reset values: all outputs 0, including mem_data and mem_start_addr. State is IDLE; byte counter and line buffer are cleared.
- Reset mid-operation: any pending mem_req drops immediately; the job is abandoned.
- All outputs are registered.
- State machine:
  - IDLE: on sw_start=1, latch sw_addr_z, sw_shift and sw_relu_en into internal registers; busy<=1; go to ACCUM.
  - ACCUM: res_ready=1. A result is accepted when res_valid && res_ready.
    - Accepted byte is written to line byte index cnt; cnt increments.
    - If cnt reaches 16, or res_last=1 on the accepted beat, go to WRITE on the same edge. On that edge: mem_req<=1, mem_data<=line including the new byte, mem_size_bytes<=cnt+1, mem_start_addr<=current address, last<=res_last.
  - WRITE: res_ready=0. Hold mem_req, mem_data, mem_size_bytes, mem_start_addr and last stable until mem_gnt=1 is sampled with mem_req=1. On that edge:
    - mem_req<=0, last<=0.
    - Address += mem_size_bytes, wrapping modulo 2^ADDR_WIDTH.
    - Clear line buffer and cnt.
    - Go to DONE if the write was last, else back to ACCUM.
    - mem_gnt while mem_req=0 is ignored.
  - DONE: done=1 for exactly one cycle; busy<=0; go to IDLE.
- Requantisation per accepted result x:
  - v = (sw_relu_en && x<0) ? 0 : x.
  - s = v >>> shift (arithmetic shift).
  - Byte = s saturated to [-128,127], two's complement.
- Unused bytes of a partial line are 0.
- sw_start while busy is ignored; latched configuration is unchanged.
- res_valid in IDLE/WRITE/DONE is not accepted, since res_ready=0 there.
- A single res_last result produces one write with size 1.
- Throughput: 1 result/cycle in ACCUM. Minimum 1 WRITE cycle per 16 bytes; with mem_gnt held high the bubble is 1 cycle.

Test Plan:
- Full line, last on beat 16: start with addr_z=0x100, shift=0, relu=0; 16 results 1..16 → one write: mem_start_addr=0x100, size=16, mem_data bytes 0x01..0x10, last=1, then done pulse, busy=0.
- Saturation: shift=2, results 1000, -1000, 300, -5 with last on the 4th → bytes 0x7F, 0x80, 0x4B, 0xFE; size=4. Repeat with relu=1 → bytes 0x7F, 0x00, 0x4B, 0x00.
- Multi-line: addr_z=0x7FFF8 (ADDR_WIDTH=19), 20 results → write 1 at 0x7FFF8, size 16, last=0; write 2 at 0x00008 (wrapped), size 4, last=1, bytes 4..15 zero.
- Back-pressure: mem_gnt delayed 5 cycles → mem_req and data stable for 6 cycles, res_ready=0 throughout, no result lost when res_valid is held. sw_start pulsed during the job is ignored.
- Reset: assert rst while in WRITE → mem_req=0, busy=0, mem_data=0 asynchronously. A new job after release starts at the new sw_addr_z with cnt=0.

Source files
------------

// File: rtl/cnn_wr_packer.sv
// cnn_wr_packer: requantises CNN results to int8 and packs them into memory write lines
module cnn_wr_packer #(
    parameter int ADDR_WIDTH   = 19,
    parameter int MEM_DATA_BUS = 128,
    parameter int RES_WIDTH    = 32,
    parameter int LOG2_BYTES   = $clog2(MEM_DATA_BUS / 8)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sw_start,
    input  logic [ADDR_WIDTH-1:0]   sw_addr_z,
    input  logic [4:0]              sw_shift,
    input  logic                    sw_relu_en,
    input  logic                    res_valid,
    input  logic [RES_WIDTH-1:0]    res_data,
    input  logic                    res_last,
    output logic                    res_ready,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_start_addr,
    output logic [LOG2_BYTES:0]     mem_size_bytes,
    output logic [MEM_DATA_BUS-1:0] mem_data,
    output logic                    last,
    input  logic                    mem_gnt,
    output logic                    busy,
    output logic                    done
);
    localparam int BYTES = MEM_DATA_BUS / 8;

    typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [4:0]              shift;
    logic                    relu_en;
    logic [LOG2_BYTES:0]     cnt;
    logic [MEM_DATA_BUS-1:0] line, line_nx;
    logic signed [RES_WIDTH-1:0] v, s;
    logic [7:0]              q;
    logic                    accept, flush, granted;

    // requantise the incoming result and merge it into the current line
    always_comb begin
        v = (relu_en && res_data[RES_WIDTH-1]) ? '0 : res_data;
        s = v >>> shift;
        q = (s > $signed(RES_WIDTH'(127))) ? 8'h7f :
            (s < -$signed(RES_WIDTH'(128))) ? 8'h80 : s[7:0];
        line_nx = line;
        line_nx[{cnt[LOG2_BYTES-1:0], 3'b000} +: 8] = q;
        accept  = res_ready && res_valid;
        flush   = accept && (res_last || cnt == (LOG2_BYTES + 1)'(BYTES - 1));
        granted = mem_req && mem_gnt;
    end

    // next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = sw_start ? ACCUM : IDLE;
            ACCUM:   state_nx = flush ? WRITE : ACCUM;
            WRITE:   state_nx = granted ? (last ? DONE : ACCUM) : WRITE;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // registered outputs, configuration, line buffer and write address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_ready      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_req        <= 1'b0;
            mem_start_addr <= '0;
            mem_size_bytes <= '0;
            mem_data       <= '0;
            last           <= 1'b0;
            addr           <= '0;
            shift          <= '0;
            relu_en        <= 1'b0;
            cnt            <= '0;
            line           <= '0;
        end else begin
            res_ready <= state_nx == ACCUM;
            busy      <= state_nx != IDLE;
            done      <= state_nx == DONE;
            if (state == IDLE && sw_start) begin
                addr    <= sw_addr_z;
                shift   <= sw_shift;
                relu_en <= sw_relu_en;
            end
            if (accept) begin
                line <= line_nx;
                cnt  <= cnt + 1'b1;
            end
            if (flush) begin
                mem_req        <= 1'b1;
                mem_data       <= line_nx;
                mem_size_bytes <= cnt + 1'b1;
                mem_start_addr <= addr;
                last           <= res_last;
            end
            if (granted) begin
                mem_req <= 1'b0;
                last    <= 1'b0;
                addr    <= addr + ADDR_WIDTH'(mem_size_bytes);
                line    <= '0;
                cnt     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cnn_wr_packer.sv
// tb_cnn_wr_packer: randomized bench for cnn_wr_packer against a byte-queue reference model
module tb_cnn_wr_packer;
    localparam int AW = 19;

    logic          clk = 1'b0, rst = 1'b1;
    logic          sw_start = 1'b0, sw_relu_en = 1'b0;
    logic [AW-1:0] sw_addr_z = '0;
    logic [4:0]    sw_shift = '0;
    logic          res_valid = 1'b0, res_last = 1'b0, mem_gnt = 1'b0;
    logic [31:0]   res_data = '0;
    logic          res_ready, mem_req, last, busy, done;
    logic [AW-1:0] mem_start_addr;
    logic [4:0]    mem_size_bytes;
    logic [127:0]  mem_data;

    int n_cmp = 0, n_bad = 0;
    int res_q[$];

    cnn_wr_packer dut (
        .clk(clk), .rst(rst), .sw_start(sw_start), .sw_addr_z(sw_addr_z),
        .sw_shift(sw_shift), .sw_relu_en(sw_relu_en), .res_valid(res_valid),
        .res_data(res_data), .res_last(res_last), .res_ready(res_ready),
        .mem_req(mem_req), .mem_start_addr(mem_start_addr),
        .mem_size_bytes(mem_size_bytes), .mem_data(mem_data), .last(last),
        .mem_gnt(mem_gnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ReLU, floor division by 2^sh, clamp to int8
    function automatic logic [7:0] q8(input int x, input int sh, input bit relu);
        longint v, d, r;
        v = (relu && x < 0) ? 0 : longint'(x);
        d = longint'(1) << sh;
        r = (v >= 0) ? v / d : -((-v + d - 1) / d);
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r[7:0];
    endfunction

    function automatic int rnd_res();
        case ($urandom_range(0, 2))
            0:       return int'($urandom_range(0, 600)) - 300;
            1:       return int'($urandom);
            default: return int'($urandom_range(0, 70000)) - 35000;
        endcase
    endfunction

    // runs one job over res_q; gdel < 0 picks a random grant delay per write
    task automatic run_job(input logic [AW-1:0] a, input int sh, input bit relu, input int gdel);
        int n, nl, idx, w, cyc, wc, dly, sz;
        bit acc, gr, fin;
        logic [7:0] eb[$];
        logic [127:0] ed;
        logic [AW-1:0] ea;
        n = res_q.size(); nl = (n + 15) / 16;
        idx = 0; w = 0; cyc = 0; wc = 0; dly = 0; acc = 0; gr = 0; fin = 0;
        foreach (res_q[i]) eb.push_back(q8(res_q[i], sh, relu));
        @(negedge clk);
        sw_start = 1; sw_addr_z = a; sw_shift = 5'(sh); sw_relu_en = relu;
        @(negedge clk);
        sw_start = 0;
        chk("busy_start", busy, 1);
        chk("ready_start", res_ready, 1);
        while (!fin && cyc < 3000) begin
            if (acc) idx++;
            if (gr) begin w++; wc = 0; end
            if (gr && w == nl) begin
                sw_start = 0; mem_gnt = 0; res_valid = 0;
                chk("done_pulse", done, 1);
                chk("busy_in_done", busy, 1);
                chk("req_drop", mem_req, 0);
                @(negedge clk);
                chk("done_clear", done, 0);
                chk("busy_end", busy, 0);
                fin = 1;
            end else begin
                sw_start = (cyc == 3);
                if (cyc == 3) begin
                    sw_addr_z = AW'($urandom); sw_shift = 5'($urandom); sw_relu_en = 1'($urandom);
                end
                if (mem_req) begin
                    ed = '0;
                    for (int k = 0; k < 16; k++)
                        if (16 * w + k < n) ed[8*k +: 8] = eb[16*w + k];
                    ea = a + AW'(16 * w);
                    sz = (n - 16 * w > 16) ? 16 : n - 16 * w;
                    chk("addr", mem_start_addr, ea);
                    chk("size", mem_size_bytes, sz);
                    chk("data", mem_data, ed);
                    chk("last", last, w == nl - 1);
                    chk("ready_in_write", res_ready, 0);
                    if (wc == 0) dly = (gdel < 0) ? $urandom_range(0, 3) : gdel;
                    mem_gnt = (wc >= dly);
                    wc++;
                end else mem_gnt = 1'($urandom_range(0, 1));
                if (idx < n) begin
                    res_valid = (res_valid && !acc) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    res_data = res_q[idx];
                    res_last = (idx == n - 1);
                end else begin
                    res_valid = 0; res_last = 0;
                end
                acc = res_valid && res_ready;
                gr = mem_req && mem_gnt;
                cyc++;
                @(negedge clk);
            end
        end
        chk("job_finished", fin, 1);
        chk("consumed", idx, n);
        sw_start = 0; mem_gnt = 0; res_valid = 0; res_last = 0;
    endtask

    initial begin
        int cyc;
        repeat (2) @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", res_ready, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_addr", mem_start_addr, 0);
        chk("rst_size", mem_size_bytes, 0);
        chk("rst_last", last, 0);
        rst = 0;

        res_q = {};
        for (int i = 1; i <= 16; i++) res_q.push_back(i);
        run_job(19'h100, 0, 0, 0);

        res_q = {1000, -1000, 300, -5};
        run_job(19'h40, 2, 0, -1);
        run_job(19'h80, 2, 1, -1);

        res_q = {};
        for (int i = 0; i < 20; i++) res_q.push_back(rnd_res());
        run_job(19'h7FFF8, 0, 0, 0);
        run_job(19'h2000, 3, 0, 5);

        res_q = {-77};
        run_job(19'h13, 0, 0, 0);

        for (int j = 0; j < 12; j++) begin
            res_q = {};
            for (int i = 0, n = $urandom_range(1, 40); i < n; i++) res_q.push_back(rnd_res());
            run_job(AW'($urandom), $urandom_range(0, 31), 1'($urandom), -1);
        end

        @(negedge clk);
        sw_start = 1; sw_addr_z = 19'h500; sw_shift = 0; sw_relu_en = 0;
        @(negedge clk);
        sw_start = 0; res_valid = 1; res_data = 32'd9; res_last = 0; mem_gnt = 0;
        cyc = 0;
        while (!mem_req && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_rise", mem_req, 1);
        #2 rst = 1;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_data", mem_data, 0);
        chk("arst_ready", res_ready, 0);
        res_valid = 0;
        @(negedge clk);
        rst = 0;
        res_q = {5, 6, 7, -8, 200};
        run_job(19'h1234, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
